// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier producing a full 2*WIDTH-bit signed or unsigned product.
// Magnitudes are multiplied unsigned over WIDTH/STEP iterations, then the sign is applied once.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_lo_o,
  output logic [WIDTH-1:0] product_hi_o
);

  localparam int K  = WIDTH / STEP;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]      LAST_COUNT = CW'(K - 1);
  localparam logic [CW-1:0]      COUNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W      = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W     = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t               state_q,  state_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q,  count_d;
  logic                 neg_q,    neg_d;
  logic [2*WIDTH-1:0]   prod_q,   prod_d;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   acc_signed;

  // The most-negative operand negates to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    a_mag = (is_signed_i && a_i[WIDTH-1]) ? (~a_i + ONE_W) : a_i;
    b_mag = (is_signed_i && b_i[WIDTH-1]) ? (~b_i + ONE_W) : b_i;
  end

  // The multiplicand is pre-shifted each iteration, so each retired multiplier bit adds in place.
  always_comb begin
    acc_sum = acc_q;
    for (int j = 0; j < STEP; j++) begin
      if (mplier_q[j]) begin
        acc_sum = acc_sum + (mcand_q << j);
      end
    end
    acc_signed = neg_q ? (~acc_q + ONE_2W) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = CALC;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          count_d  = '0;
          neg_d    = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        count_d  = count_q + COUNT_ONE;
        if (count_q == LAST_COUNT) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        acc_d   = acc_signed;
        prod_d  = acc_signed;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
    end
  end

  assign busy_o       = (state_q == CALC) || (state_q == SIGN);
  assign done_o       = (state_q == DONE);
  assign product_lo_o = prod_q[WIDTH-1:0];
  assign product_hi_o = prod_q[2*WIDTH-1:WIDTH];

endmodule
